spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Shares the single SPI master port (sclk/cs/mosi/miso) between NUM_REQ on-chip requesters.
- Arbitrates round-robin, then sequences one full-duplex DATA_W-bit frame per grant: cs framing, sclk generation, MSB-first shift out, sample in.
- Returns the received byte with a done pulse.
- Sits between client logic and the chip-level SPI pins; also drives the led activity indicator.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, frame width in bits.
- CLK_DIV, 2, sclk half-period in clock_in cycles (>=1).
- CS_GAP, 2, minimum clock_in cycles cs stays high between frames (>=1).

Ports:
- clock_in  input  1  system clock.
- rs  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester transaction request, level.
- tx_data  input  NUM_REQ*DATA_W  per-requester transmit word; slice i belongs to req[i].
- gnt  output  NUM_REQ  one-hot grant.
- done  output  NUM_REQ  one-cycle completion pulse, one-hot.
- rx_data  output  DATA_W  last received word, valid from the done cycle until the next done.
- busy  output  1  high while any frame is in progress (grant to end of GAP).
- sclk  output  1  SPI clock, mode 0 (idle low).
- cs  output  1  chip select, active-low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- led  output  1  equals busy.

Behaviour:
- Reset (rs=0, async): all outputs are 0 except cs=1. Specifically gnt=0, done=0, rx_data=0, busy=0, sclk=0, mosi=0, led=0. FSM goes to IDLE; round-robin pointer goes to 0. Reset mid-frame aborts the frame immediately; no done is issued.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - On any req high, next edge: gnt[w] is set, tx_data slice w is latched into the shift register, cs is driven 0, mosi takes the MSB, busy=1.
  - w is the first set req at or after the pointer, wrapping modulo NUM_REQ.
- SETUP: CLK_DIV cycles; sclk=0.
- SHIFT: 2*DATA_W sclk half-periods of CLK_DIV cycles each, starting with a rising edge.
  - Rising edge: sample miso into the LSB of the rx shift register.
  - Falling edge: shift tx left; mosi presents the next bit.
  - After the final (2*DATA_W-th) edge, sclk=0.
- HOLD: CLK_DIV cycles; cs is still low.
  - Total cs-low time is CLK_DIV*(2*DATA_W+2) cycles.
- Completion (on leaving HOLD):
  - cs=1, mosi=0.
  - rx_data loads from the rx shift register.
  - done[w] pulses for 1 cycle; gnt[w] drops in the cycle after done.
  - Pointer becomes (w+1) mod NUM_REQ.
- GAP: CS_GAP cycles with cs=1 and busy=1. busy falls on entry to IDLE. Arbitration for the next frame happens in the IDLE cycle, so back-to-back frames have a cs-high time of CS_GAP+1 cycles.
- Handshake: the requester holds req and tx_data stable from assertion until its done.
  - If req drops after grant, the frame still completes and done is still issued.
  - tx_data is sampled only at grant.
  - req still high after done is a new request; it competes again under round-robin.
- Simultaneous requests: exactly one grant per frame; rotation guarantees no starvation (max wait NUM_REQ-1 frames).
- mosi changes only while sclk is low or at the setup edge; it is never changed at a rising sclk edge.

Optional Feature:
- SPI_LOOPBACK_EN defined: the internal miso sample source is the registered mosi; the external miso is ignored. A frame returns rx_data == transmitted word. This is used for self-test.
- Not defined: the external miso is sampled; no loopback logic is present.

Decomposition:
- Package spi_arb_pkg holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the default constants DATA_W=8, CLK_DIV=2, CS_GAP=2;
  - a function giving the cs-low cycle count.
- Sub-module spi_shift_engine:
  - contents: sclk divider, edge counter, tx/rx shift registers;
  - interface: start, tx_word, rx_word, last_edge;
  - the arbiter FSM and pointer stay in spi_txn_arbiter.

Test Plan (bench uses default parameters throughout):
- Single-requester frame: req[0]=1, tx_data[0]=0xAC, miso model returns 0x35 MSB-first.
  - mosi sampled on sclk rises is 1,0,1,0,1,1,0,0.
  - cs low exactly 36 cycles; 8 sclk pulses.
  - rx_data=0x35; done[0] one cycle; done[1] never.
- Simultaneous requests: req=2'b11 right after reset with tx 0x11/0x22.
  - Grant order is 0 then 1; mosi frames are 0x11 then 0x22.
  - cs high between the frames for exactly 3 cycles.
- Fairness: both reqs held high for 6 frames.
  - done alternates 0,1,0,1,0,1; gnt is never 2'b11.
- Req drop after grant: req[1] pulsed for 1 cycle.
  - Full frame runs; done[1] asserted; busy returns 0 after GAP.
- Reset mid-SHIFT: rs=0 at the 5th sclk edge.
  - Same cycle: cs=1, sclk=0, gnt=0, busy=0, led=0.
  - No done is issued; the next frame after release starts from pointer 0.
- SPI_LOOPBACK_EN build: tx 0x5A with external miso tied to 1 -> rx_data=0x5A.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_CS_GAP  = 2;

  // Clock cycles cs stays low for one frame: setup + 2*DATA_W half-periods + hold.
  function automatic int unsigned cs_low_cycles(input int unsigned clk_div,
                                                input int unsigned data_w);
    return clk_div * (2 * data_w + 2);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: sclk divider, edge counter, tx/rx shift registers.
// SPI_LOOPBACK_EN: sample the registered mosi instead of the external miso.
module spi_shift_engine #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_word,
  output logic              last_edge
);

  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EC_W  = $clog2(EDGES + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EC_W-1:0]   edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic              tick;
  logic              miso_src;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign miso_src    = tx_sr_q[DATA_W-1];
`else
  assign miso_src    = miso;
`endif

  // One tick per half-period; the tick after the final edge closes the last half-period.
  assign tick      = run && (div_q == DIV_W'(CLK_DIV - 1));
  assign last_edge = tick && (edge_q == EC_W'(EDGES));

  assign sclk    = sclk_q;
  assign mosi    = tx_sr_q[DATA_W-1];
  assign rx_word = rx_sr_q;

  // Divider, edge sequencing, sample on rise and shift on fall.
  always_comb begin
    div_d   = div_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    if (start) begin
      div_d   = '0;
      edge_d  = '0;
      sclk_d  = 1'b0;
      tx_sr_d = tx_word;
      rx_sr_d = '0;
    end else if (run) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick && (edge_q != EC_W'(EDGES))) begin
        edge_d = edge_q + 1'b1;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_src};
        end else begin
          tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
    end else begin
      div_q   <= div_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master port between NUM_REQ requesters.
// SPI_LOOPBACK_EN: frames return the transmitted word (see spi_shift_engine).
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CS_GAP  = DEF_CS_GAP
) (
  input  logic                      clock_in,
  input  logic                      rs,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      sclk,
  output logic                      cs,
  output logic                      mosi,
  input  logic                      miso,
  output logic                      led
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               cs_q, cs_d;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_pick;
  logic [PTR_W-1:0]   arb_cand;
  logic               eng_start;
  logic               eng_run;
  logic [DATA_W-1:0]  eng_tx_word;
  logic [DATA_W-1:0]  eng_rx_word;
  logic               eng_last_edge;

  assign eng_run     = (state_q == SETUP) || (state_q == SHIFT);
  assign eng_tx_word = tx_data[arb_pick*DATA_W +: DATA_W];

  spi_shift_engine #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk       (clock_in),
    .rst_n     (rs),
    .start     (eng_start),
    .run       (eng_run),
    .tx_word   (eng_tx_word),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .rx_word   (eng_rx_word),
    .last_edge (eng_last_edge)
  );

  // Round-robin pick: first set req at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_pick  = arb_cand;
      end
    end
  end

  // Frame sequencing FSM, grant/done generation and pointer rotation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    eng_start = 1'b0;
    // grant is held through the done cycle and released one cycle later
    if (done_q != '0) begin
      gnt_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d         = SETUP;
          cnt_d           = '0;
          win_d           = arb_pick;
          gnt_d           = '0;
          gnt_d[arb_pick] = 1'b1;
          cs_d            = 1'b0;
          eng_start       = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (eng_last_edge) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d       = GAP;
          cnt_d         = '0;
          cs_d          = 1'b1;
          done_d[win_q] = 1'b1;
          rx_data_d     = eng_rx_word;
          ptr_d         = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers; reset aborts any frame in flight.
  always_ff @(posedge clock_in or negedge rs) begin
    if (!rs) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs      = cs_q;
  assign busy    = (state_q != IDLE);
  assign led     = busy;

endmodule
